// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback versus buffered
// long-latency unit results, with a busy scoreboard and a starvation guard.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_result,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_result,
  input  logic        issue_lu,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  dec_rd,
  output logic        hazard_stall,
  output logic        wb_hold,
  output logic [4:0]  rd_b,
  output logic        reg_write_b,
  output logic [31:0] result_b
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO,
    SRC_LU
  } wb_src_e;

  wb_entry_t         fifo_mem [DEPTH];
  wb_entry_t         head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [31:0]       busy_q, busy_d;
  logic              lu_ready_q, lu_ready_d;
  logic [4:0]        rd_q, rd_d;
  logic              we_q, we_d;
  logic [31:0]       result_q, result_d;

  wb_src_e           src;
  logic              fifo_empty;
  logic              pipe_req;
  logic              lu_accept;
  logic              push;
  logic              pop;
  logic              lu_commit;
  logic [4:0]        lu_commit_rd;

  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];
  // A pipeline write to x0 has no architectural effect, so it never competes.
  assign pipe_req   = pipe_valid && (pipe_rd != 5'd0);
  assign wb_hold    = (starve_q == STARVE_C);
  assign lu_accept  = lu_valid && lu_ready_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    src = SRC_NONE;
    if (pipe_req && !wb_hold) begin
      src = SRC_PIPE;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
    end else if (lu_accept) begin
      src = SRC_LU;
    end
  end

  assign pop          = (src == SRC_FIFO);
  assign push         = lu_accept && (src != SRC_LU);
  assign lu_commit    = (src == SRC_FIFO) || (src == SRC_LU);
  assign lu_commit_rd = (src == SRC_FIFO) ? head.rd : lu_rd;

  always_comb begin
    rd_d     = rd_q;
    result_d = result_q;
    we_d     = 1'b0;
    unique case (src)
      SRC_PIPE: begin
        rd_d     = pipe_rd;
        result_d = pipe_result;
        we_d     = 1'b1;
      end
      SRC_FIFO: begin
        rd_d     = head.rd;
        result_d = head.data;
        we_d     = (head.rd != 5'd0);
      end
      SRC_LU: begin
        rd_d     = lu_rd;
        result_d = lu_result;
        we_d     = (lu_rd != 5'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    lu_ready_d = (count_d < DEPTH_C);
    // Only cycles where a buffered result is passed over by the pipeline count as starvation.
    starve_d   = (src == SRC_PIPE && !fifo_empty) ? starve_q + STV_W'(1) : '0;
  end

  // The clear is applied before the set so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (lu_commit) begin
      busy_d[lu_commit_rd] = 1'b0;
    end
    if (issue_lu && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign hazard_stall = ((rs1    != 5'd0) && busy_q[rs1])
                      | ((rs2    != 5'd0) && busy_q[rs2])
                      | ((dec_rd != 5'd0) && busy_q[dec_rd]);

  // NOTE: storage is not reset; occupancy and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{rd: lu_rd, data: lu_result};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      busy_q     <= '0;
      lu_ready_q <= 1'b1;
      rd_q       <= '0;
      we_q       <= 1'b0;
      result_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all update from the same pre-edge values.
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
      lu_ready_q <= lu_ready_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      result_q   <= result_d;
    end
  end

  assign lu_ready    = lu_ready_q;
  assign rd_b        = rd_q;
  assign reg_write_b = we_q;
  assign result_b    = result_q;

endmodule
